// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial adder/subtractor, LSB first.
//
// A single 1-bit full adder plus a carry flip-flop processes one bit per
// clock. An accepted request takes WIDTH RUN cycles, then a one-cycle DONE
// state pulses `done`. Subtraction is computed as a + ~b + 1 by inverting
// each b bit and seeding the carry with 1.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32), default 16
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   start  request; accepted in IDLE or DONE, ignored while busy
//   op     0 = a + b, 1 = a - b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   high while an operation is running (state RUN)
//   done   one-cycle pulse when out/c hold a fresh result (state DONE)
//   out    result, held until the final bit of the next operation
//   c      add: carry-out; subtract: borrow (inverted carry-out)
//   ovf    only when SERIAL_ADDSUB_OVF_EN is defined: signed overflow,
//          updated and held like c
module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             op_r;
    logic             b_eff_s;
    logic             bit_s;
    logic             cout_s;
    logic             last_s;
    logic             accept_s;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

    // One-bit datapath slice and request acceptance decode
    always_comb begin
        b_eff_s  = b_sh_r[0] ^ op_r;
        bit_s    = fa_sum(a_sh_r[0], b_eff_s, carry_r);
        cout_s   = fa_carry(a_sh_r[0], b_eff_s, carry_r);
        last_s   = (cnt_r == CNT_W'(WIDTH - 1));
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand shifters, carry, bit counter and held result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            op_r     <= 1'b0;
            out      <= '0;
            c        <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= '0;
            cnt_r    <= '0;
            // Carry seeded with op supplies the +1 of a + ~b + 1
            carry_r  <= op;
            op_r     <= op;
        end else if (state_r == RUN) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_sh_r <= {bit_s, res_sh_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + CNT_W'(1);
            carry_r  <= cout_s;
            // The visible result only moves on the final bit, so out/c stay
            // stable for the whole of the following operation
            if (last_s) begin
                out <= {bit_s, res_sh_r[WIDTH-1:1]};
                c   <= cout_s ^ op_r;
`ifdef SERIAL_ADDSUB_OVF_EN
                // carry_r here is the carry into the MSB
                ovf <= carry_r ^ cout_s;
`endif
            end
        end
    end

    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub -- directed self-checking bench for serial_addsub
// (WIDTH = 16). Covers reset state, add/subtract results, latency, the
// one-cycle done pulse, back-to-back requests, start held during RUN,
// asynchronous reset mid-operation and, when SERIAL_ADDSUB_OVF_EN is
// defined, the signed overflow flag.
module tb_serial_addsub;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        c;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out),
`ifdef SERIAL_ADDSUB_OVF_EN
        .ovf   (ovf),
`endif
        .c     (c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its done pulse. Called just after
    // a clock edge (or at a negedge); the next rising edge is acceptance E0.
    // With hold set, start stays high and a/b/op keep changing during RUN.
    task automatic do_op(input string tag, input logic o, input logic [15:0] xa,
                         input logic [15:0] xb, input logic hold,
                         input logic [15:0] eo, input logic ec, input logic eovf);
        int          busy_n;
        int          done_n;
        int          out_chg;
        logic [15:0] prev;
        prev  = out;
        op    = o;
        a     = xa;
        b     = xb;
        start = 1'b1;
        busy_n  = 0;
        done_n  = 0;
        out_chg = 0;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_n++;
            if (done) done_n++;
            if (out !== prev) out_chg++;
            if (hold) begin
                a  = a ^ 16'hFFFF;
                b  = b + 16'h0101;
                op = ~op;
            end
        end
        @(posedge clk); #1;
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
        chk({tag, "_early_done"}, 32'(done_n), 32'd0);
        chk({tag, "_out_stable"}, 32'(out_chg), 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_out"}, {16'd0, out}, {16'd0, eo});
        chk({tag, "_c"}, {31'd0, c}, {31'd0, ec});
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
`else
        if (eovf === 1'bx) $display("note: %s", tag);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_seen;
        start = 1'b0;
        op    = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;

        // Reset forces outputs before any clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        chk("rst_c", {31'd0, c}, 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // First start accepted at the first edge after release
        do_op("sub_5_3", 1'b1, 16'd5, 16'd3, 1'b0, 16'h0002, 1'b0, 1'b0);
        do_op("sub_3_5", 1'b1, 16'd3, 16'd5, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        // Issued while done is high: back-to-back acceptance
        do_op("add_b2b", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

        // Start held through RUN with changing operands
        do_op("add_hold", 1'b0, 16'h1234, 16'h1111, 1'b1, 16'h2345, 1'b0, 1'b0);
        // start still high in DONE: next request accepted right away
        do_op("add_next", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        do_op("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_sub", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);

        // Abort with reset after seven RUN cycles
        @(posedge clk); #1;
        op    = 1'b0;
        a     = 16'h00FF;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_out", {16'd0, out}, 32'd0);
        chk("abort_c", {31'd0, c}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        do_op("add_after_rst", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
